// File: rtl/timer_bank_if.sv
// Register bus and interrupt lines between a CPU and the timer bank.
interface timer_bank_if;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        timer_int;
  logic        timer_int_ack;
  logic [3:0]  int_id;

  modport master (output we, addr, wdata, timer_int_ack,
                  input  rdata, timer_int, int_id);
  modport slave  (input  we, addr, wdata, timer_int_ack,
                  output rdata, timer_int, int_id);
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_CH independent up-counting timers with a shared, priority-encoded interrupt.
// Channel 0 comes out of reset running so it behaves like the legacy single timer.
module timer_bank #(
  parameter int NUM_CH        = 4,
  parameter int CNT_WIDTH     = 32,
  parameter int DEFAULT_LIMIT = 100
) (
  input  logic       clk,
  input  logic       reset,
  timer_bank_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LIMIT_RST = CNT_WIDTH'(DEFAULT_LIMIT);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LIMIT  = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [3:0] ch;
  logic [1:0] sel;
  logic       ch_ok;
  logic       unused_addr;

  logic                 en_q    [NUM_CH];
  logic                 en_d    [NUM_CH];
  logic                 per_q   [NUM_CH];
  logic                 per_d   [NUM_CH];
  logic                 ie_q    [NUM_CH];
  logic                 ie_d    [NUM_CH];
  logic                 pend_q  [NUM_CH];
  logic                 pend_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] limit_q [NUM_CH];
  logic [CNT_WIDTH-1:0] limit_d [NUM_CH];
  logic [CNT_WIDTH-1:0] count_q [NUM_CH];
  logic [CNT_WIDTH-1:0] count_d [NUM_CH];
  logic                 hit     [NUM_CH];
  logic                 sel_ch  [NUM_CH];

  logic       irq;
  logic [3:0] irq_id;

  function automatic logic [31:0] zext(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_WIDTH-1:0] = v;
    return r;
  endfunction

  assign ch          = bus.addr[7:4];
  assign sel         = bus.addr[3:2];
  assign ch_ok       = ({1'b0, ch} < 5'(NUM_CH));
  assign unused_addr = ^bus.addr[1:0];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_ch[i] = ch_ok && (ch == 4'(i));
      hit[i]    = en_q[i] && (limit_q[i] != '0) && (count_q[i] == limit_q[i] - ONE);
    end
  end

  // Scan from the top so the lowest pending channel is the one left in irq_id.
  always_comb begin
    irq    = 1'b0;
    irq_id = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_q[i] && ie_q[i]) begin
        irq    = 1'b1;
        irq_id = 4'(i);
      end
    end
  end

  assign bus.timer_int = irq;
  assign bus.int_id    = irq_id;

  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch[i]) begin
        case (sel)
          REG_CTRL:   bus.rdata = {29'd0, ie_q[i], per_q[i], en_q[i]};
          REG_LIMIT:  bus.rdata = zext(limit_q[i]);
          REG_COUNT:  bus.rdata = zext(count_q[i]);
          REG_STATUS: bus.rdata = {31'd0, pend_q[i]};
          default:    bus.rdata = '0;
        endcase
      end
    end
  end

  // Later assignments override earlier ones: a CTRL write beats the one-shot
  // auto-disable, and expiry beats every way of clearing PEND.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      en_d[i]    = en_q[i];
      per_d[i]   = per_q[i];
      ie_d[i]    = ie_q[i];
      pend_d[i]  = pend_q[i];
      limit_d[i] = limit_q[i];
      count_d[i] = count_q[i];

      if (en_q[i] && (limit_q[i] != '0)) begin
        count_d[i] = hit[i] ? '0 : count_q[i] + ONE;
      end
      if (hit[i] && !per_q[i]) begin
        en_d[i] = 1'b0;
      end

      if (bus.we && sel_ch[i] && (sel == REG_CTRL)) begin
        en_d[i]  = bus.wdata[0];
        per_d[i] = bus.wdata[1];
        ie_d[i]  = bus.wdata[2];
        if (!en_q[i] && bus.wdata[0]) begin
          count_d[i] = '0;
        end
      end
      if (bus.we && sel_ch[i] && (sel == REG_LIMIT)) begin
        limit_d[i] = bus.wdata[CNT_WIDTH-1:0];
        count_d[i] = '0;
      end
      if (bus.we && sel_ch[i] && (sel == REG_STATUS) && bus.wdata[0]) begin
        pend_d[i] = 1'b0;
      end
      if (bus.timer_int_ack && irq && (irq_id == 4'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (hit[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i]    <= (i == 0);
        per_q[i]   <= (i == 0);
        ie_q[i]    <= (i == 0);
        pend_q[i]  <= 1'b0;
        limit_q[i] <= (i == 0) ? LIMIT_RST : '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        en_q[i]    <= en_d[i];
        per_q[i]   <= per_d[i];
        ie_q[i]    <= ie_d[i];
        pend_q[i]  <= pend_d[i];
        limit_q[i] <= limit_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: defaults, one-shot, priority, collisions, boundaries, reset.
module tb_timer_bank;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  timer_bank_if bus ();

  timer_bank #(.NUM_CH(4), .CNT_WIDTH(32), .DEFAULT_LIMIT(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic ack();
    bus.timer_int_ack = 1'b1;
    tick();
    bus.timer_int_ack = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL rst_int got %0b want 0", bus.timer_int); end
    checks++; if (bus.int_id !== 4'd0) begin errors++; $display("FAIL rst_id got %0d want 0", bus.int_id); end
    rd(8'h00, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL rst_ctrl0 got %0h want 7", d); end
    rd(8'h04, d);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL rst_limit0 got %0d want 100", d); end
    rd(8'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl1 got %0h want 0", d); end
    rd(8'h08, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count0 got %0d want 0", d); end
  endtask

  task automatic test_default();
    logic [31:0] d;
    repeat (99) tick();
    rd(8'h08, d);
    checks++; if (d !== 32'd99) begin errors++; $display("FAIL def_count99 got %0d want 99", d); end
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL def_early got %0b want 0", bus.timer_int); end
    tick();
    checks++; if (bus.timer_int !== 1'b1 || bus.int_id !== 4'd0) begin
      errors++; $display("FAIL def_expire got int=%0b id=%0d want int=1 id=0", bus.timer_int, bus.int_id); end
    rd(8'h08, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL def_wrap got %0d want 0", d); end
    ack();
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL def_ack got %0b want 0", bus.timer_int); end
    repeat (98) tick();
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL def_second_early got %0b want 0", bus.timer_int); end
    tick();
    checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL def_second got %0b want 1", bus.timer_int); end
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h1);
    rd(8'h0C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL def_w1c got %0h want 0", d); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    wr(8'h14, 32'd5);
    wr(8'h10, 32'h5);
    repeat (4) tick();
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL os_early got %0b want 0", bus.timer_int); end
    tick();
    checks++; if (bus.timer_int !== 1'b1 || bus.int_id !== 4'd1) begin
      errors++; $display("FAIL os_expire got int=%0b id=%0d want int=1 id=1", bus.timer_int, bus.int_id); end
    rd(8'h10, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL os_ctrl got %0h want 4", d); end
    repeat (3) tick();
    rd(8'h18, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL os_count_hold got %0d want 0", d); end
    wr(8'h1C, 32'h1);
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL os_clear got %0b want 0", bus.timer_int); end
  endtask

  task automatic test_priority();
    wr(8'h24, 32'd10);
    wr(8'h34, 32'd10);
    wr(8'h20, 32'h5);
    wr(8'h30, 32'h5);
    repeat (9) tick();
    checks++; if (bus.timer_int !== 1'b1 || bus.int_id !== 4'd2) begin
      errors++; $display("FAIL pri_ch2 got int=%0b id=%0d want int=1 id=2", bus.timer_int, bus.int_id); end
    tick();
    checks++; if (bus.int_id !== 4'd2) begin errors++; $display("FAIL pri_both got %0d want 2", bus.int_id); end
    ack();
    checks++; if (bus.timer_int !== 1'b1 || bus.int_id !== 4'd3) begin
      errors++; $display("FAIL pri_ack1 got int=%0b id=%0d want int=1 id=3", bus.timer_int, bus.int_id); end
    ack();
    checks++; if (bus.timer_int !== 1'b0 || bus.int_id !== 4'd0) begin
      errors++; $display("FAIL pri_ack2 got int=%0b id=%0d want int=0 id=0", bus.timer_int, bus.int_id); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(8'h14, 32'd4);
    wr(8'h10, 32'h7);
    repeat (4) tick();
    checks++; if (bus.timer_int !== 1'b1 || bus.int_id !== 4'd1) begin
      errors++; $display("FAIL col_first got int=%0b id=%0d want int=1 id=1", bus.timer_int, bus.int_id); end
    repeat (3) tick();
    ack();
    rd(8'h1C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL col_ack got %0h want 1", d); end
    repeat (3) tick();
    wr(8'h1C, 32'h1);
    rd(8'h1C, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL col_w1c got %0h want 1", d); end
    ack();
    rd(8'h1C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL col_plain_ack got %0h want 0", d); end
    wr(8'h10, 32'h0);
    wr(8'h1C, 32'h1);
  endtask

  task automatic test_boundaries();
    logic [31:0] d;
    logic [31:0] s;
    wr(8'h24, 32'd1);
    wr(8'h20, 32'h7);
    for (int k = 0; k < 3; k++) begin
      wr(8'h2C, 32'h1);
      rd(8'h2C, s);
      rd(8'h28, d);
      checks++; if (s !== 32'h1 || d !== 32'h0) begin
        errors++; $display("FAIL lim1_iter%0d got pend=%0h count=%0d want pend=1 count=0", k, s, d); end
    end
    wr(8'h20, 32'h0);
    wr(8'h2C, 32'h1);
    wr(8'h34, 32'd20);
    wr(8'h30, 32'h1);
    repeat (5) tick();
    rd(8'h38, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL mid_count got %0d want 5", d); end
    wr(8'h34, 32'd30);
    rd(8'h38, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_limit_wr got %0d want 0", d); end
    repeat (2) tick();
    rd(8'h38, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL mid_resume got %0d want 2", d); end
    wr(8'h34, 32'd0);
    repeat (4) tick();
    wr(8'h38, 32'h55);
    rd(8'h38, d);
    rd(8'h3C, s);
    checks++; if (d !== 32'd0 || s !== 32'd0) begin
      errors++; $display("FAIL lim0_frozen got count=%0d pend=%0h want 0 0", d, s); end
    wr(8'h30, 32'h0);
    wr(8'hF4, 32'd7);
    rd(8'hF0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oob_ctrl got %0h want 0", d); end
    rd(8'hF4, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL oob_limit got %0h want 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(8'h00, 32'h7);
    repeat (100) tick();
    checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL rm_pend got %0b want 1", bus.timer_int); end
    repeat (57) tick();
    rd(8'h08, d);
    checks++; if (d !== 32'd57) begin errors++; $display("FAIL rm_count57 got %0d want 57", d); end
    #1;
    reset = 1'b1;
    rd(8'h08, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rm_count got %0d want 0", d); end
    rd(8'h0C, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rm_status got %0h want 0", d); end
    checks++; if (bus.timer_int !== 1'b0 || bus.int_id !== 4'd0) begin
      errors++; $display("FAIL rm_int got int=%0b id=%0d want 0 0", bus.timer_int, bus.int_id); end
    rd(8'h14, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rm_limit1 got %0d want 0", d); end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.we            = 1'b0;
    bus.addr          = 8'h00;
    bus.wdata         = 32'h0;
    bus.timer_int_ack = 1'b0;
    repeat (2) tick();
    test_reset();
    tick();
    reset = 1'b0;
    test_default();
    test_oneshot();
    test_priority();
    test_collision();
    test_boundaries();
    test_reset_mid();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
